// File: rtl/onehot_gen.sv
// onehot_gen: binary index to one-hot encoder with a walking-one sequencer.
//   - IDLE: each accepted encode request yields 1<<in_idx (or zero + out_err
//     when the index is beyond DATA_WIDTH) one cycle later.
//   - WALK: after walk_start, emits walk_len+1 words, each rotated left by one
//     from the previous, advancing on every output handshake.
//   - One output register; a word is held stable until out_ready.
// Optional build macro ONEHOT_GEN_CHECK_EN adds a sticky checker that flags
// any valid, non-error word whose popcount is not exactly one (chk_fail).
// Without the macro, chk_fail is tied low and no checker logic is built.
module onehot_gen #(
   parameter int DATA_WIDTH = 32,
   parameter int IDX_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IDX_WIDTH-1:0]  in_idx,
   input  logic                  walk_start,
   input  logic [IDX_WIDTH-1:0]  walk_idx,
   input  logic [IDX_WIDTH-1:0]  walk_len,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_err,
   output logic                  busy,
   output logic                  chk_fail
);

   typedef enum logic {ST_IDLE, ST_WALK} state_t;

   // DATA_WIDTH <= 2**IDX_WIDTH, so it always fits in IDX_WIDTH+1 bits
   localparam logic [IDX_WIDTH:0]    DW_L = (IDX_WIDTH+1)'(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

   state_t                state_q,     state_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic                  out_err_q,   out_err_d;
   logic [IDX_WIDTH-1:0]  walk_cnt_q,  walk_cnt_d;   // words left after the current one

   logic                  out_free;
   logic                  out_hs;
   logic                  enc_go;
   logic                  walk_go;
   logic                  idx_oob;
   logic [IDX_WIDTH-1:0]  walk_mod;

   assign out_free = !out_valid_q || out_ready;
   assign out_hs   = out_valid_q && out_ready;
   // walk_start blocks encode acceptance so a walk always wins a tie
   assign in_ready = (state_q == ST_IDLE) && out_free && !walk_start;
   assign enc_go   = in_valid && in_ready;
   assign walk_go  = walk_start && (state_q == ST_IDLE) && out_free;
   assign idx_oob  = ({1'b0, in_idx} >= DW_L);
   assign walk_mod = IDX_WIDTH'({1'b0, walk_idx} % DW_L);

   // Next-state: load encode/walk words, rotate on walk handshakes, drain otherwise
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      walk_cnt_d  = walk_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (walk_go) begin
               state_d     = ST_WALK;
               out_valid_d = 1'b1;
               out_data_d  = ONE << walk_mod;
               out_err_d   = 1'b0;
               walk_cnt_d  = walk_len;
            end else if (enc_go) begin
               out_valid_d = 1'b1;
               out_data_d  = idx_oob ? '0 : (ONE << in_idx);
               out_err_d   = idx_oob;
            end else if (out_hs) begin
               out_valid_d = 1'b0;
            end
         end
         ST_WALK: begin
            if (out_hs) begin
               if (walk_cnt_q == '0) begin
                  state_d     = ST_IDLE;
                  out_valid_d = 1'b0;
               end else begin
                  walk_cnt_d = walk_cnt_q - IDX_WIDTH'(1);
                  out_data_d = {out_data_q[DATA_WIDTH-2:0], out_data_q[DATA_WIDTH-1]};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and output register; reset drops any pending word or walk
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         walk_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         walk_cnt_q  <= walk_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;
   assign busy      = (state_q == ST_WALK);

`ifdef ONEHOT_GEN_CHECK_EN
   logic chk_fail_q, chk_fail_d;

   // Sticky flag: a presented non-error word must carry exactly one set bit
   always_comb begin
      chk_fail_d = chk_fail_q;
      if (out_valid_q && !out_err_q && ($countones(out_data_q) != 1))
         chk_fail_d = 1'b1;
   end

   // Checker flop, cleared only by reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) chk_fail_q <= 1'b0;
      else         chk_fail_q <= chk_fail_d;
   end

   assign chk_fail = chk_fail_q;
`else
   assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_gen.sv
// Directed bench for onehot_gen: a 32-bit instance plus a 24-bit instance
// sharing the same stimulus (the narrow one exercises out-of-range indices
// and walk start reduction). Inputs change and outputs are sampled 1ns
// after the rising edge.
module tb_onehot_gen;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic [4:0]  in_idx;
   logic        walk_start;
   logic [4:0]  walk_idx;
   logic [4:0]  walk_len;
   logic        out_ready;

   logic        in_ready,  out_valid,  out_err,  busy,  chk_fail;
   logic [31:0] out_data;
   logic        in_ready2, out_valid2, out_err2, busy2, chk_fail2;
   logic [23:0] out_data2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   onehot_gen #(.DATA_WIDTH(32), .IDX_WIDTH(5)) u_dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
      .walk_start(walk_start), .walk_idx(walk_idx), .walk_len(walk_len),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_err(out_err), .busy(busy), .chk_fail(chk_fail)
   );

   onehot_gen #(.DATA_WIDTH(24), .IDX_WIDTH(5)) u_dut24 (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready2), .in_idx(in_idx),
      .walk_start(walk_start), .walk_idx(walk_idx), .walk_len(walk_len),
      .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
      .out_err(out_err2), .busy(busy2), .chk_fail(chk_fail2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] walk_exp [4];
      logic [23:0] walk_exp24 [4];
      walk_exp   = '{32'h4000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0002};
      walk_exp24 = '{24'h00_0040, 24'h00_0080, 24'h00_0100, 24'h00_0200};

      resetn = 1'b0; in_valid = 1'b0; in_idx = '0; walk_start = 1'b0;
      walk_idx = '0; walk_len = '0; out_ready = 1'b1;
      tick(); tick();

      // reset state
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data",  out_data, 32'd0);
      chk("rst_err",   {31'd0, out_err}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_chk",   {31'd0, chk_fail}, 32'd0);
      resetn = 1'b1;
      tick();
      chk("idle_ready", {31'd0, in_ready}, 32'd1);

      // single encode, index 3
      in_valid = 1'b1; in_idx = 5'd3;
      tick();
      in_valid = 1'b0;
      chk("enc3_valid", {31'd0, out_valid}, 32'd1);
      chk("enc3_data",  out_data, 32'h0000_0008);
      chk("enc3_err",   {31'd0, out_err}, 32'd0);
      chk("enc3_data24", {8'd0, out_data2}, 32'h0000_0008);

      // back-to-back encodes at full rate: 31, 0, then 30
      in_valid = 1'b1; in_idx = 5'd31;
      tick();
      chk("enc31_data",  out_data, 32'h8000_0000);
      chk("enc31_err24", {31'd0, out_err2}, 32'd1);
      chk("enc31_data24", {8'd0, out_data2}, 32'd0);
      in_idx = 5'd0;
      tick();
      chk("enc0_data", out_data, 32'h0000_0001);
      in_idx = 5'd30;
      tick();
      in_valid = 1'b0;
      chk("enc30_data",   out_data, 32'h4000_0000);
      chk("enc30_err",    {31'd0, out_err}, 32'd0);
      chk("enc30_err24",  {31'd0, out_err2}, 32'd1);
      chk("enc30_data24", {8'd0, out_data2}, 32'd0);
      tick();
      chk("drain_valid", {31'd0, out_valid}, 32'd0);

      // walk from 30, four words (24-bit instance starts at 30 mod 24 = 6)
      walk_start = 1'b1; walk_idx = 5'd30; walk_len = 5'd3;
      #1;
      chk("walk_blocks_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         walk_start = 1'b0;
         chk($sformatf("walk_w%0d", i), out_data, walk_exp[i]);
         chk($sformatf("walk24_w%0d", i), {8'd0, out_data2}, {8'd0, walk_exp24[i]});
         chk($sformatf("walk_busy%0d", i), {31'd0, busy}, 32'd1);
      end
      chk("walk_err", {31'd0, out_err}, 32'd0);
      tick();
      chk("walk_end_busy",  {31'd0, busy}, 32'd0);
      chk("walk_end_valid", {31'd0, out_valid}, 32'd0);
      chk("walk_end_ready", {31'd0, in_ready}, 32'd1);

      // backpressure: word held, second request stalls, walk_start ignored
      out_ready = 1'b0;
      in_valid = 1'b1; in_idx = 5'd5;
      tick();
      in_idx = 5'd7;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("hold_data%0d", i), out_data, 32'h0000_0020);
         chk($sformatf("hold_ready%0d", i), {31'd0, in_ready}, 32'd0);
         tick();
      end
      walk_start = 1'b1; walk_idx = 5'd1; walk_len = 5'd0;
      tick();
      walk_start = 1'b0;
      chk("hold_walk_ignored", {31'd0, busy}, 32'd0);
      chk("hold_data_after",   out_data, 32'h0000_0020);
      out_ready = 1'b1;
      #1;
      chk("release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("second_req_data", out_data, 32'h0000_0080);
      tick();

      // reset in the middle of a walk
      walk_start = 1'b1; walk_idx = 5'd0; walk_len = 5'd5;
      tick();
      walk_start = 1'b0;
      chk("rwalk_w0", out_data, 32'h0000_0001);
      tick();
      chk("rwalk_w1", out_data, 32'h0000_0002);
      resetn = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_busy",  {31'd0, busy}, 32'd0);
      chk("async_rst_data",  out_data, 32'd0);
      tick();
      resetn = 1'b1;
      tick();
      in_valid = 1'b1; in_idx = 5'd0;
      tick();
      in_valid = 1'b0;
      chk("post_rst_enc", out_data, 32'h0000_0001);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      tick();

      // walk_start and in_valid together: walk wins, encode waits
      walk_start = 1'b1; walk_idx = 5'd2; walk_len = 5'd1;
      in_valid = 1'b1; in_idx = 5'd9;
      #1;
      chk("tie_ready", {31'd0, in_ready}, 32'd0);
      tick();
      walk_start = 1'b0;
      chk("tie_w0", out_data, 32'h0000_0004);
      chk("tie_busy", {31'd0, busy}, 32'd1);
      chk("tie_ready_walk", {31'd0, in_ready}, 32'd0);
      tick();
      chk("tie_w1", out_data, 32'h0000_0008);
      tick();
      chk("tie_walk_done", {31'd0, out_valid}, 32'd0);
      chk("tie_ready_idle", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("tie_enc_data", out_data, 32'h0000_0200);
      chk("tie_enc_err",  {31'd0, out_err}, 32'd0);
      chk("chk_fail_end",   {31'd0, chk_fail}, 32'd0);
      chk("chk_fail24_end", {31'd0, chk_fail2}, 32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
